// File: rtl/mel_log_compress.sv
// mel_log_compress
//   Log2 compression of mel filterbank energies, feeding the DCT stage.
//   Each accepted unsigned fixed-point energy becomes a signed Q5.10 log2
//   value. Every result carries its mel bin index, plus a last flag on bin
//   NUM_BANDS-1. A zero input yields LOG_FLOOR.
//
//   Optional feature: define MEL_LOG_INTERP_EN to add a fourth stage. This
//   stage interpolates linearly between adjacent LUT entries. Without the
//   macro the latency is 3 and no multiplier is built.
//
// Ports
//   clk        clock
//   rst        asynchronous, active-high reset
//   in_valid   input energy valid
//   in_ready   stage can accept input (low only while the output is stalled)
//   in_data    mel energy, unsigned Q(IN_W-IN_FRAC).IN_FRAC
//   in_last    last bin of frame, from the mel filterbank
//   out_valid  log value valid
//   out_ready  downstream accepts
//   out_data   log2(in_data), signed Q5.10
//   out_bin    mel bin index, 0..NUM_BANDS-1
//   out_last   high with bin NUM_BANDS-1
//   frame_err  sticky: in_last disagreed with the bin count; cleared by rst
module mel_log_compress #(
  parameter int                 NUM_BANDS = 40,
  parameter int                 IN_W      = 32,
  parameter int                 IN_FRAC   = 16,
  parameter logic signed [15:0] LOG_FLOOR = -16'sd16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [15:0]     out_data,
  output logic [5:0]             out_bin,
  output logic                   out_last,
  output logic                   frame_err
);

  localparam int         PW       = $clog2(IN_W);
  localparam logic [5:0] LAST_BIN = 6'(NUM_BANDS - 1);

  // round(1024*log2(1+i/64)), i = 0..64
  localparam logic [10:0] LUT [65] = '{
    11'd0,    11'd23,   11'd45,   11'd68,   11'd90,   11'd111,  11'd132,  11'd153,
    11'd174,  11'd194,  11'd214,  11'd234,  11'd254,  11'd273,  11'd292,  11'd311,
    11'd330,  11'd348,  11'd366,  11'd384,  11'd402,  11'd419,  11'd436,  11'd454,
    11'd470,  11'd487,  11'd504,  11'd520,  11'd536,  11'd552,  11'd568,  11'd584,
    11'd599,  11'd614,  11'd629,  11'd644,  11'd659,  11'd674,  11'd689,  11'd703,
    11'd717,  11'd731,  11'd745,  11'd759,  11'd773,  11'd787,  11'd800,  11'd813,
    11'd827,  11'd840,  11'd853,  11'd866,  11'd879,  11'd891,  11'd904,  11'd916,
    11'd929,  11'd941,  11'd953,  11'd965,  11'd977,  11'd989,  11'd1001, 11'd1012,
    11'd1024
  };

  // Integer part (p - IN_FRAC) in Q5.10 plus the fractional LUT value.
  // The sum is formed in 17 bits and truncated to 16.
  function automatic logic signed [15:0] log_sum(input logic [PW-1:0] pos,
                                                 input logic [10:0]   frac,
                                                 input logic          zero);
    logic signed [16:0] ex;
    logic signed [16:0] s;
    ex = signed'(17'(pos)) - signed'(17'(IN_FRAC));
    s  = (ex <<< 10) + signed'(17'(frac));
    return zero ? LOG_FLOOR : s[15:0];
  endfunction

`ifdef MEL_LOG_INTERP_EN
  function automatic logic [10:0] interp(input logic [10:0] a,
                                         input logic [10:0] b,
                                         input logic [3:0]  m);
    logic [14:0] prod;
    prod = 15'(b - a) * 15'(m);
    return a + 11'(prod >> 4);
  endfunction
`endif

  logic adv;
  logic xfer_in;

  // The whole pipe freezes while the output holds an unaccepted value.
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;
  assign xfer_in  = in_valid && adv;

  logic [5:0] bin_cnt;

  // A premature in_last resyncs the count to 0. A missing in_last on the
  // final bin is flagged, and the count still wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt   <= '0;
      frame_err <= 1'b0;
    end else if (xfer_in) begin
      bin_cnt <= (in_last || bin_cnt == LAST_BIN) ? 6'd0 : bin_cnt + 6'd1;
      if (in_last != (bin_cnt == LAST_BIN))
        frame_err <= 1'b1;
    end
  end

  // ---- stage 1: leading-one detect ----
  logic [PW-1:0] lod;
  always_comb begin
    lod = '0;
    for (int i = 0; i < IN_W; i++)
      if (in_data[i]) lod = PW'(i);
  end

  logic            vld_p1, zero_p1, last_p1;
  logic [IN_W-1:0] data_p1;
  logic [PW-1:0]   pos_p1;
  logic [5:0]      bin_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      last_p1 <= 1'b0;
      data_p1 <= '0;
      pos_p1  <= '0;
      bin_p1  <= '0;
    end else if (adv) begin
      vld_p1  <= xfer_in;
      zero_p1 <= (in_data == '0);
      last_p1 <= (bin_cnt == LAST_BIN);
      data_p1 <= in_data;
      pos_p1  <= lod;
      bin_p1  <= bin_cnt;
    end
  end

  // ---- stage 2: normalise, LUT read ----
  logic [PW-1:0] shamt;
  assign shamt = PW'(IN_W - 1) - pos_p1;

  // Only the mantissa bits just below the normalised MSB are kept.
`ifdef MEL_LOG_INTERP_EN
  logic [9:0] mant;
  assign mant = 10'((data_p1 << shamt) >> (IN_W - 11));
`else
  logic [5:0] mant;
  assign mant = 6'((data_p1 << shamt) >> (IN_W - 7));
`endif

  logic          vld_p2, zero_p2, last_p2;
  logic [PW-1:0] pos_p2;
  logic [5:0]    bin_p2;
  logic [10:0]   lut_a_p2;
`ifdef MEL_LOG_INTERP_EN
  logic [10:0]   lut_b_p2;
  logic [3:0]    m4_p2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2   <= 1'b0;
      zero_p2  <= 1'b0;
      last_p2  <= 1'b0;
      pos_p2   <= '0;
      bin_p2   <= '0;
      lut_a_p2 <= '0;
`ifdef MEL_LOG_INTERP_EN
      lut_b_p2 <= '0;
      m4_p2    <= '0;
`endif
    end else if (adv) begin
      vld_p2   <= vld_p1;
      zero_p2  <= zero_p1;
      last_p2  <= last_p1;
      pos_p2   <= pos_p1;
      bin_p2   <= bin_p1;
`ifdef MEL_LOG_INTERP_EN
      lut_a_p2 <= LUT[7'(mant[9:4])];
      lut_b_p2 <= LUT[7'(mant[9:4]) + 7'd1];
      m4_p2    <= mant[3:0];
`else
      lut_a_p2 <= LUT[7'(mant)];
`endif
    end
  end

`ifdef MEL_LOG_INTERP_EN
  // ---- stage 3: interpolate between adjacent LUT entries ----
  logic          vld_p3, zero_p3, last_p3;
  logic [PW-1:0] pos_p3;
  logic [5:0]    bin_p3;
  logic [10:0]   frac_p3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      zero_p3 <= 1'b0;
      last_p3 <= 1'b0;
      pos_p3  <= '0;
      bin_p3  <= '0;
      frac_p3 <= '0;
    end else if (adv) begin
      vld_p3  <= vld_p2;
      zero_p3 <= zero_p2;
      last_p3 <= last_p2;
      pos_p3  <= pos_p2;
      bin_p3  <= bin_p2;
      frac_p3 <= interp(lut_a_p2, lut_b_p2, m4_p2);
    end
  end

  // ---- stage 4: exponent + fraction, output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p3;
      out_data  <= log_sum(pos_p3, frac_p3, zero_p3);
      out_bin   <= bin_p3;
      out_last  <= last_p3;
    end
  end
`else
  // ---- stage 3: exponent + fraction, output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_bin   <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_valid <= vld_p2;
      out_data  <= log_sum(pos_p2, lut_a_p2, zero_p2);
      out_bin   <= bin_p2;
      out_last  <= last_p2;
    end
  end
`endif

endmodule

// File: tb/tb_mel_log_compress.sv
// tb_mel_log_compress
//   Directed bench for mel_log_compress: reset state, single-value log2
//   conversions, full frames with and without an output stall, frame
//   checking and mid-frame reset.
module tb_mel_log_compress;

  localparam int NB = 40;
`ifdef MEL_LOG_INTERP_EN
  localparam int          LAT     = 4;
  localparam logic [15:0] EXP_MAX = 16'd16383;
`else
  localparam int          LAT     = 3;
  localparam logic [15:0] EXP_MAX = 16'd16372;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last, frame_err;
  logic [15:0] out_data;
  logic [5:0]  out_bin;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mel_log_compress dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bin   (out_bin),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One isolated input; checks latency, value and bin index.
  task automatic run_one(input string tag, input logic [31:0] v,
                         input logic [15:0] exp, input logic [5:0] exp_bin);
    int k;
    in_valid = 1'b1;
    in_data  = v;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = '0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, "_lat"}, k, LAT);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_bin"}, out_bin, exp_bin);
  endtask

  // Streams n inputs back-to-back. in_last is raised on input last_pos
  // (-1: never). out_ready is dropped for st_len cycles from cycle st_from.
  task automatic stream(input string tag, input int n, input int last_pos,
                        input int st_from, input int st_len);
    logic [31:0] vin [$];
    logic [15:0] ed  [$];
    logic [5:0]  eb  [$];
    logic        el  [$];
    int   b = 0, ii = 0, oc = 0, c = 0, first = -1;
    logic xi, xo;
    for (int i = 0; i < n; i++) begin
      vin.push_back(32'h0001_0000 << (i % 16));
      ed.push_back(16'((i % 16) * 1024));
      eb.push_back(6'(b));
      el.push_back(b == NB - 1);
      b = (b == NB - 1 || i == last_pos) ? 0 : b + 1;
    end
    while (oc < n && c < n + 60) begin
      in_valid  = (ii < n);
      in_data   = (ii < n) ? vin[ii] : 32'd0;
      in_last   = (ii < n) && (ii == last_pos);
      out_ready = !(c >= st_from && c < st_from + st_len);
      #1;
      if (st_len > 0 && c == st_from) begin
        chk({tag, "_stall_ovld"}, out_valid, 1);
        chk({tag, "_stall_irdy"}, in_ready, 0);
      end
      if (out_valid && oc < n) begin
        if (first < 0) first = c;
        chk({tag, "_data"}, out_data, ed[oc]);
        chk({tag, "_bin"}, out_bin, eb[oc]);
        chk({tag, "_last"}, out_last, el[oc]);
      end
      xi = in_valid && in_ready;
      xo = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (xi) ii++;
      if (xo) oc++;
      c++;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, oc, n);
    chk({tag, "_first"}, first, LAT);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_bin", out_bin, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;

    run_one("one",     32'h0001_0000, 16'h0000, 6'd0);
    run_one("two",     32'h0002_0000, 16'd1024, 6'd1);
    run_one("half",    32'h0000_8000, 16'hFC00, 6'd2);
    run_one("three",   32'h0003_0000, 16'd1623, 6'd3);
    run_one("zero",    32'h0000_0000, 16'hC000, 6'd4);
    run_one("max",     32'hFFFF_FFFF, EXP_MAX,  6'd5);
    run_one("onehalf", 32'h0001_8000, 16'd599,  6'd6);
    run_one("lsb",     32'h0000_0001, 16'hC000, 6'd7);
    run_one("q075",    32'h0000_C000, 16'hFE57, 6'd8);

    do_reset();
    stream("frame", 40, 39, 0, 0);
    chk("frame_err_clean", frame_err, 0);

    do_reset();
    stream("stall", 40, 39, 15, 5);
    chk("stall_err_clean", frame_err, 0);

    do_reset();
    stream("early", 20, 10, 0, 0);
    chk("early_frame_err", frame_err, 1);

    do_reset();
    stream("nolast", 41, -1, 0, 0);
    chk("nolast_frame_err", frame_err, 1);

    // Mid-frame reset with data in flight and frame_err already set.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0001_0000 << i;
      in_last  = (i == 2);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("pre_rst_ovld", out_valid, 1);
    chk("pre_rst_ferr", frame_err, 1);
    rst = 1'b1;
    #1;
    chk("midrst_ovld", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_bin", out_bin, 0);
    chk("midrst_last", out_last, 0);
    chk("midrst_ferr", frame_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ovld", out_valid, 0);
    stream("after_rst", 3, -1, 0, 0);
    chk("after_rst_ferr", frame_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
